// File: rtl/fft_pkg.sv
// ---------------------------------------------------------------------------
// fft_pkg
// Shared types and constants for the 32-point radix-2 FFT control path.
//   seq_state_e : sequencer FSM encoding (2 bits)
//   CNT_W       : width of the butterfly index for the default transform size
//   STAGE_W     : width of the stage index (enough for up to 8 stages)
// ---------------------------------------------------------------------------
package fft_pkg;

  localparam int NUMSTAGES_DEF = 5;
  localparam int CNT_W         = NUMSTAGES_DEF - 2;
  localparam int STAGE_W       = 3;
  localparam int LAT_W         = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

  // Preload value for the drain down-counter; it terminates at zero, so a
  // drain of L cycles starts from L-1.
  function automatic logic [LAT_W-1:0] drain_preload(input int latency);
    if (latency > 0) begin
      return LAT_W'(latency - 1);
    end
    return '0;
  endfunction

endpackage

// File: rtl/fft_delay_line.sv
// ---------------------------------------------------------------------------
// fft_delay_line
// Fixed-depth shift register used to align the write-side address/enable
// bundle with the butterfly pipeline. DEPTH = 0 degenerates to a wire.
//   clk    : clock, rising edge
//   rst    : asynchronous active-high reset, clears every stage
//   data_i : bundle entering the pipeline
//   data_o : bundle delayed by DEPTH cycles
// ---------------------------------------------------------------------------
module fft_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o
);

  if (DEPTH == 0) begin : g_bypass
    assign data_o = data_i;
  end else begin : g_pipe
    logic [WIDTH-1:0] pipe_q [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) begin
          pipe_q[i] <= '0;
        end
      end else begin
        pipe_q[0] <= data_i;
        for (int i = 1; i < DEPTH; i++) begin
          pipe_q[i] <= pipe_q[i-1];
        end
      end
    end

    assign data_o = pipe_q[DEPTH-1];
  end

endmodule

// File: rtl/fft_sequencer.sv
// ---------------------------------------------------------------------------
// fft_sequencer
// Walks every butterfly stage of the FFT core. Issues the read-side
// {counter, stage} pair, a write-side copy delayed by the butterfly latency,
// and drains the pipeline between stages so a stage never reads a bank entry
// the previous stage has not yet written.
//
// Ports
//   clk          : clock, rising edge
//   rst          : asynchronous active-high reset (aborts a transform)
//   start        : begin a transform, only honoured in IDLE
//   hold         : stall read issue while in RUN
//   busy         : high in RUN and DRAIN
//   done         : one-cycle pulse after the last write of the last stage
//   counter_r    : read-side butterfly index (qualify with rd_en)
//   stage_num_r  : read-side stage index (qualify with rd_en)
//   rd_en        : read addresses valid this cycle
//   wr_counter   : counter_r delayed by BFLY_LATENCY
//   wr_stage     : stage_num_r delayed by BFLY_LATENCY
//   wr_en        : rd_en delayed by BFLY_LATENCY
//
// state | meaning
// IDLE  | waiting for start
// RUN   | issuing reads, counter advances on every non-hold cycle
// DRAIN | no reads, waiting BFLY_LATENCY cycles for writes to land
// DONE  | done pulse, back to IDLE next cycle
// ---------------------------------------------------------------------------
module fft_sequencer
  import fft_pkg::*;
#(
  parameter int NUMSTAGES    = NUMSTAGES_DEF,
  parameter int BFLY_LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 hold,
  output logic                 busy,
  output logic                 done,
  output logic [NUMSTAGES-3:0] counter_r,
  output logic [STAGE_W-1:0]   stage_num_r,
  output logic                 rd_en,
  output logic [NUMSTAGES-3:0] wr_counter,
  output logic [STAGE_W-1:0]   wr_stage,
  output logic                 wr_en
);

  localparam int                 CW         = NUMSTAGES - 2;
  localparam int                 WR_W       = 1 + CW + STAGE_W;
  localparam logic [CW-1:0]      CNT_LAST   = '1;
  localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(NUMSTAGES - 1);
  localparam logic [LAT_W-1:0]   DRAIN_INIT = drain_preload(BFLY_LATENCY);
  localparam bit                 HAS_DRAIN  = (BFLY_LATENCY > 0);

  seq_state_e         state_q;
  logic [CW-1:0]      cnt_q;
  logic [CW-1:0]      cnt_d;
  logic [STAGE_W-1:0] stage_q;
  logic [STAGE_W-1:0] stage_d;
  logic [LAT_W-1:0]   drain_q;
  logic               busy_q;
  logic               done_q;
  logic               issue;

  logic [WR_W-1:0]    rd_bundle;
  logic [WR_W-1:0]    wr_bundle;

  assign cnt_d   = cnt_q + 1'b1;
  assign stage_d = stage_q + 1'b1;

  // Read issue follows hold in the same cycle, so a stalled cycle costs
  // exactly one cycle and the frozen counter is what gets issued afterwards.
  assign issue = (state_q == ST_RUN) && !hold;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      stage_q <= '0;
      drain_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            stage_q <= '0;
            busy_q  <= 1'b1;
          end
        end

        ST_RUN: begin
          if (!hold) begin
            cnt_q <= cnt_d;
            if (cnt_q == CNT_LAST) begin
              if (HAS_DRAIN) begin
                state_q <= ST_DRAIN;
                drain_q <= DRAIN_INIT;
              end else if (stage_q == STAGE_LAST) begin
                state_q <= ST_DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                // Zero latency: next stage reads straight after this one.
                stage_q <= stage_d;
              end
            end
          end
        end

        ST_DRAIN: begin
          if (drain_q == '0) begin
            if (stage_q == STAGE_LAST) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_RUN;
              stage_q <= stage_d;
            end
          end else begin
            drain_q <= drain_q - 1'b1;
          end
        end

        ST_DONE: begin
          state_q <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign counter_r   = cnt_q;
  assign stage_num_r = stage_q;
  assign rd_en       = issue;

  // The whole bundle is delayed, not just the enable, so the write address
  // always matches the read that produced the data.
  assign rd_bundle = {issue, cnt_q, stage_q};

  fft_delay_line #(
    .WIDTH (WR_W),
    .DEPTH (BFLY_LATENCY)
  ) u_wr_delay (
    .clk    (clk),
    .rst    (rst),
    .data_i (rd_bundle),
    .data_o (wr_bundle)
  );

  assign wr_en      = wr_bundle[WR_W-1];
  assign wr_counter = wr_bundle[WR_W-2 -: CW];
  assign wr_stage   = wr_bundle[STAGE_W-1:0];

endmodule

// File: tb/tb_fft_sequencer.sv
`timescale 1ns/1ps
module tb_fft_sequencer;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic hold;

  always #5 clk = ~clk;

  logic [3:0] busy_w, done_w, rd_w, wr_w;
  logic [2:0] cnt_w  [4];
  logic [2:0] stg_w  [4];
  logic [2:0] wcnt_w [4];
  logic [2:0] wstg_w [4];

  // Instance 0 is the default build; 1..3 cover latencies 0, 1 and 3.
  for (genvar g = 0; g < 4; g++) begin : g_dut
    fft_sequencer #(
      .NUMSTAGES    (5),
      .BFLY_LATENCY ((g == 0) ? 2 : (g == 1) ? 0 : (g == 2) ? 1 : 3)
    ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .hold        (hold),
      .busy        (busy_w[g]),
      .done        (done_w[g]),
      .counter_r   (cnt_w[g]),
      .stage_num_r (stg_w[g]),
      .rd_en       (rd_w[g]),
      .wr_counter  (wcnt_w[g]),
      .wr_stage    (wstg_w[g]),
      .wr_en       (wr_w[g])
    );
  end

  int n_checks = 0;
  int n_fail   = 0;

  int busy_cnt [4];
  int rd_cnt   [4];
  int wr_cnt   [4];
  int done_cnt [4];
  int done_cyc [4];
  int seq_err  [4];
  int wr_err   [4];
  int ovl_err  [4];
  int exp_idx  [4];
  int first_rd [4][8];
  int last_wr  [4][8];
  logic       hrd  [4][256];
  logic [2:0] hcnt [4][256];
  logic [2:0] hstg [4][256];

  function automatic int lat_of(input int g);
    case (g)
      0:       return 2;
      1:       return 0;
      2:       return 1;
      default: return 3;
    endcase
  endfunction

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    for (int g = 0; g < 4; g++) begin
      busy_cnt[g] = 0; rd_cnt[g] = 0; wr_cnt[g] = 0; done_cnt[g] = 0;
      done_cyc[g] = -1; seq_err[g] = 0; wr_err[g] = 0; ovl_err[g] = 0;
      exp_idx[g] = 0;
      for (int s = 0; s < 8; s++) begin
        first_rd[g][s] = -1;
        last_wr[g][s]  = -1;
      end
    end
  endtask

  task automatic sample(input int c);
    for (int g = 0; g < 4; g++) begin
      int   l;
      logic exp_wr;
      l = lat_of(g);
      hrd[g][c]  = rd_w[g];
      hcnt[g][c] = cnt_w[g];
      hstg[g][c] = stg_w[g];
      if (busy_w[g]) busy_cnt[g]++;
      if (done_w[g]) begin
        if (done_cnt[g] == 0) done_cyc[g] = c;
        done_cnt[g]++;
        if (rd_w[g] || wr_w[g]) ovl_err[g]++;
      end
      if (rd_w[g]) begin
        if (int'(stg_w[g]) != exp_idx[g] / 8 || int'(cnt_w[g]) != exp_idx[g] % 8)
          seq_err[g]++;
        if (first_rd[g][stg_w[g]] < 0) first_rd[g][stg_w[g]] = c;
        exp_idx[g]++;
        rd_cnt[g]++;
      end
      exp_wr = (c >= l) ? hrd[g][c-l] : 1'b0;
      if (wr_w[g] != exp_wr) wr_err[g]++;
      else if (exp_wr && (wcnt_w[g] != hcnt[g][c-l] || wstg_w[g] != hstg[g][c-l]))
        wr_err[g]++;
      if (wr_w[g]) begin
        wr_cnt[g]++;
        last_wr[g][wstg_w[g]] = c;
      end
    end
  endtask

  // Caller has start=1 before entry; the next posedge is E0 and cycle c is
  // the interval after edge Ec.
  task automatic run_tx(input string name, input int ncyc, input int hold_c,
                        input int hold_len, input int s1, input int s2,
                        input logic [3:0] mask, input bit chain);
    clear_stats();
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk);
      #1;
      start = (c == s1) || (c == s2) || (chain && c == ncyc - 1);
      hold  = (hold_len > 0) && (c >= hold_c) && (c < hold_c + hold_len);
      @(negedge clk);
      sample(c);
      if (c == 0 && mask[0]) begin
        check_val({name, "_c0_rd"},   int'(rd_w[0]),   1);
        check_val({name, "_c0_busy"}, int'(busy_w[0]), 1);
        check_val({name, "_c0_cnt"},  int'(cnt_w[0]),  0);
      end
      if (hold) begin
        check_val({name, "_hold_rd"},  int'(rd_w[0]),  0);
        check_val({name, "_hold_cnt"}, int'(cnt_w[0]), 5);
        check_val({name, "_hold_stg"}, int'(stg_w[0]), 2);
      end
    end
    hold  = 1'b0;
    for (int g = 0; g < 4; g++) begin
      if (mask[g]) begin
        string p;
        int    exp_len;
        int    haz;
        p       = $sformatf("%s_L%0d", name, lat_of(g));
        exp_len = 5 * (8 + lat_of(g)) + hold_len;
        haz     = 0;
        for (int s = 0; s < 4; s++)
          if (first_rd[g][s+1] >= 0 && first_rd[g][s+1] <= last_wr[g][s]) haz++;
        check_val({p, "_done_cnt"}, done_cnt[g], 1);
        check_val({p, "_done_cyc"}, done_cyc[g], exp_len);
        check_val({p, "_busy_cyc"}, busy_cnt[g], exp_len);
        check_val({p, "_rd_cnt"},   rd_cnt[g],   40);
        check_val({p, "_wr_cnt"},   wr_cnt[g],   40);
        check_val({p, "_seq_err"},  seq_err[g],  0);
        check_val({p, "_wr_err"},   wr_err[g],   0);
        check_val({p, "_hazard"},   haz,         0);
        check_val({p, "_done_ovl"}, ovl_err[g],  0);
      end
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1; start = 1'b0; hold = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    int rdone;
    rst = 1'b1; start = 1'b0; hold = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_busy",  int'(busy_w), 0);
    check_val("rst_done",  int'(done_w), 0);
    check_val("rst_rd",    int'(rd_w),   0);
    check_val("rst_wr",    int'(wr_w),   0);
    check_val("rst_cnt",   int'(cnt_w[0]),  0);
    check_val("rst_wstg",  int'(wstg_w[0]), 0);
    rst = 1'b0;

    // nominal transform on all latencies
    @(posedge clk); #1 start = 1'b1;
    run_tx("nom", 60, 0, 0, -1, -1, 4'b1111, 1'b0);

    // hold for 3 cycles at stage 2, counter 5 (cycle 25 at default latency)
    @(posedge clk); #1 start = 1'b1;
    run_tx("hold", 63, 25, 3, -1, -1, 4'b1111, 1'b0);

    // start re-pulsed mid-run and in the DONE cycle; latencies 0/1 are idle
    // by cycle 50 and would legitimately restart, so only 2 and 3 are judged
    @(posedge clk); #1 start = 1'b1;
    run_tx("ign", 60, 0, 0, 10, 50, 4'b1001, 1'b0);

    // reset mid-run at stage 3, counter 4
    apply_reset();
    @(posedge clk); #1 start = 1'b1;
    rdone = 0;
    for (int c = 0; c <= 34; c++) begin
      @(posedge clk);
      #1 start = 1'b0;
      if (done_w[0]) rdone++;
    end
    check_val("mid_stg", int'(stg_w[0]), 3);
    check_val("mid_cnt", int'(cnt_w[0]), 4);
    check_val("mid_rd",  int'(rd_w[0]),  1);
    #2 rst = 1'b1;
    #1;
    check_val("arst_busy", int'(busy_w), 0);
    check_val("arst_rd",   int'(rd_w),   0);
    check_val("arst_wr",   int'(wr_w),   0);
    check_val("arst_cnt",  int'(cnt_w[0]), 0);
    check_val("arst_stg",  int'(stg_w[0]), 0);
    check_val("arst_wcnt", int'(wcnt_w[0]), 0);
    repeat (3) begin
      @(negedge clk);
      if (done_w[0]) rdone++;
    end
    check_val("arst_no_done", rdone, 0);
    rst = 1'b0;
    @(posedge clk); #1 start = 1'b1;
    run_tx("post_rst", 60, 0, 0, -1, -1, 4'b1111, 1'b0);

    // back-to-back: start on the first IDLE cycle after done (cycle 51)
    @(posedge clk); #1 start = 1'b1;
    run_tx("b2b_a", 52, 0, 0, -1, -1, 4'b0111, 1'b1);
    run_tx("b2b_b", 52, 0, 0, -1, -1, 4'b0111, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
